sort_engine: RTL and testbench

- Sequential sorting core of the Sorter datapath.
- Accepts a frame of N unsigned 8-bit values over a valid/ready input stream.
- Sorts the frame in place with odd-even transposition, one pass per clock.
- Streams the frame out in ascending order over a valid/ready output stream. The output feeds the 8-bit output register stage (register_8) downstream.

---
 rtl/sorter_pkg.sv | 11 +
 rtl/cmp_swap.sv | 18 +
 rtl/sort_engine.sv | 132 +++++++++++++
 tb/tb_sort_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared constants for the Sorter datapath: FSM state encoding and default frame geometry.
package sorter_pkg;

    localparam int unsigned SORT_N_DEF = 8;
    localparam int unsigned SORT_W_DEF = 8;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange cell: lo gets the smaller operand, hi the larger.
module cmp_swap #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap_c;

    // Strict compare keeps equal values in place.
    assign swap_c = (a > b);
    assign lo     = swap_c ? b : a;
    assign hi     = swap_c ? a : b;

endmodule

// File: rtl/sort_engine.sv
// Frame sorter: loads N elements, runs N odd-even transposition passes in place,
// then streams the frame out in ascending order.
module sort_engine
    import sorter_pkg::*;
#(
    parameter int unsigned N  = SORT_N_DEF,
    parameter int unsigned W  = SORT_W_DEF,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned   AW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;
    logic [CW-1:0] pass_cnt_q, pass_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [W-1:0]  mem_q    [N];
    logic [W-1:0]  mem_d    [N];
    logic [W-1:0]  even_res [N];
    logic [W-1:0]  odd_res  [N];
    logic          in_fire;
    logic          out_fire;

    // Even pass network: pairs (0,1), (2,3), ... (N-2,N-1).
    for (genvar i = 0; i < N / 2; i++) begin : g_even
        cmp_swap #(.W(W)) u_cs (
            .a  (mem_q[2*i]),
            .b  (mem_q[2*i+1]),
            .lo (even_res[2*i]),
            .hi (even_res[2*i+1])
        );
    end

    // Odd pass network: pairs (1,2) ... (N-3,N-2); the end elements pass through.
    for (genvar i = 0; i < N / 2 - 1; i++) begin : g_odd
        cmp_swap #(.W(W)) u_cs (
            .a  (mem_q[2*i+1]),
            .b  (mem_q[2*i+2]),
            .lo (odd_res[2*i+1]),
            .hi (odd_res[2*i+2])
        );
    end
    assign odd_res[0]   = mem_q[0];
    assign odd_res[N-1] = mem_q[N-1];

    assign in_ready   = (state_q == ST_LOAD) && !reset;
    assign out_valid  = (state_q == ST_DRAIN);
    assign busy       = (state_q == ST_SORT) || (state_q == ST_DRAIN);
    assign out_data   = out_valid ? mem_q[rd_cnt_q[AW-1:0]] : '0;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign frame_done = out_fire && (rd_cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        pass_cnt_d = pass_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        for (int k = 0; k < N; k++) begin
            mem_d[k] = mem_q[k];
        end
        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    mem_d[ld_cnt_q[AW-1:0]] = in_data;
                    if (ld_cnt_q == LAST) begin
                        state_d    = ST_SORT;
                        ld_cnt_d   = '0;
                        pass_cnt_d = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + CW'(1);
                    end
                end
            end
            ST_SORT: begin
                for (int k = 0; k < N; k++) begin
                    mem_d[k] = pass_cnt_q[0] ? odd_res[k] : even_res[k];
                end
                if (pass_cnt_q == LAST) begin
                    state_d  = ST_DRAIN;
                    rd_cnt_d = '0;
                end else begin
                    pass_cnt_d = pass_cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    if (rd_cnt_q == LAST) begin
                        state_d  = ST_LOAD;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            ld_cnt_q   <= '0;
            pass_cnt_q <= '0;
            rd_cnt_q   <= '0;
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            for (int k = 0; k < N; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: table of frames with expected sorted output,
// scoreboard queue, backpressure, input gaps, mid-sort reset and back-to-back frames.
module tb_sort_engine;

    localparam int unsigned N = 8;
    localparam int unsigned W = 8;

    typedef logic [N-1:0][W-1:0] frame_t;
    typedef struct packed {
        frame_t     din;
        frame_t     exp;
        logic [3:0] gap;
        logic       bp;
        logic       junk;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         frame_done;

    int n_tests;
    int n_fail;
    logic [W-1:0] sb_q[$];
    vec_t tbl [6];

    sort_engine #(.N(N), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_t mk8(input logic [7:0] a0, input logic [7:0] a1,
                                   input logic [7:0] a2, input logic [7:0] a3,
                                   input logic [7:0] a4, input logic [7:0] a5,
                                   input logic [7:0] a6, input logic [7:0] a7);
        frame_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    // Drive one frame starting at a negedge; ends one negedge after the last accept.
    task automatic load_frame(input vec_t v);
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                for (int g = 0; g < int'(v.gap); g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'hAA;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = v.din[k];
            #1;
            check("load_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        for (int k = 0; k < N; k++) sb_q.push_back(v.exp[k]);
        in_valid = v.junk;
        in_data  = 8'hAA;
    endtask

    // Count negedges from the last accept until out_valid rises.
    task automatic wait_sort();
        int lat;
        lat = 1;
        while (!out_valid && lat < 4 * N) begin
            check("sort_in_ready", 32'(in_ready), 32'd0);
            check("sort_busy", 32'(busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(N + 1));
    endtask

    task automatic drain(input logic bp);
        int beats;
        int cyc;
        logic stalled;
        logic [W-1:0] held;
        logic [W-1:0] expv;
        beats   = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (beats < N && cyc < 10 * N) begin
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            #1;
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("drain_busy", 32'(busy), 32'd1);
            if (stalled) check("hold_data", 32'(out_data), 32'(held));
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    expv = sb_q.pop_front();
                    check("out_data", 32'(out_data), 32'(expv));
                end
                check("frame_done", 32'(frame_done), 32'(beats == N - 1));
                if (beats == N - 1) in_valid = 1'b0;
                beats++;
                stalled = 1'b0;
            end else begin
                check("no_done_stall", 32'(frame_done), 32'd0);
                stalled = 1'b1;
                held    = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_beats", 32'(beats), 32'(N));
        out_ready = 1'b1;
        #1;
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("post_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        tbl[0] = '{din: mk8(8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4),
                   exp: mk8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9),
                   gap: 4'd0, bp: 1'b0, junk: 1'b0};
        tbl[1] = '{din: mk8(8'hFF, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'h80, 8'h01),
                   exp: mk8(8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF),
                   gap: 4'd0, bp: 1'b0, junk: 1'b0};
        tbl[2] = '{din: mk8(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80),
                   exp: mk8(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80),
                   gap: 4'd0, bp: 1'b1, junk: 1'b0};
        tbl[3] = '{din: mk8(8'h42, 8'h17, 8'h42, 8'h03, 8'h99, 8'h00, 8'hC8, 8'h17),
                   exp: mk8(8'h00, 8'h03, 8'h17, 8'h17, 8'h42, 8'h42, 8'h99, 8'hC8),
                   gap: 4'd3, bp: 1'b0, junk: 1'b1};
        tbl[4] = '{din: mk8(8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33),
                   exp: mk8(8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33),
                   gap: 4'd0, bp: 1'b1, junk: 1'b0};
        tbl[5] = '{din: mk8(8'hFF, 8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h60, 8'h40, 8'h20),
                   exp: mk8(8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'hFF),
                   gap: 4'd0, bp: 1'b0, junk: 1'b1};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Frames run back-to-back: each load starts right after the previous frame_done.
        for (int i = 0; i < 6; i++) begin
            load_frame(tbl[i]);
            wait_sort();
            drain(tbl[i].bp);
        end

        // Abort a frame at pass 4 of SORT with an asynchronous reset.
        load_frame('{din: mk8(8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20),
                     exp: mk8(8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90),
                     gap: 4'd0, bp: 1'b0, junk: 1'b0});
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        check("mid_rel_busy", 32'(busy), 32'd0);
        @(negedge clk);
        load_frame('{din: mk8(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1),
                     exp: mk8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8),
                     gap: 4'd0, bp: 1'b0, junk: 1'b0});
        wait_sort();
        drain(1'b0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
